// File: rtl/stereo_frame_tx.sv
// -----------------------------------------------------------------------------
// stereo_frame_tx
//
// Reads a left and a right 8-bit greyscale frame from a frame RAM. It drives
// them as a continuous pixel stream for the feature-processing top. Each eye
// is one unbroken valid burst of IMG_HEIGHT*IMG_WIDTH pixels in raster order.
// Each burst is followed by exactly GAP_CYCLES cycles with valid low.
//
// Optional feature (compile-time macro STEREO_TX_TESTPAT_EN):
//   Adds the input test_mode, which is sampled together with start. When it is
//   set, the RAM is not read. A synthetic pattern is emitted instead:
//   row^col for the left eye and row^(col+4) for the right eye. This gives a
//   4-pixel disparity. Framing is identical to memory mode.
//
// Ports:
//   clk            in   1       clock
//   rst            in   1       asynchronous, active-high reset
//   start          in   1       request one L+R frame pair (sampled in IDLE)
//   test_mode      in   1       synthetic pattern select (macro builds only)
//   busy           out  1       high from the cycle after accepted start until done
//   done           out  1       one-cycle pulse after the right-frame gap
//   mem_en         out  1       frame RAM read enable
//   mem_addr       out  ADDR_W  L pixel k at k, R pixel k at N+k
//   mem_data       in   8       RAM read data, valid 1 cycle after mem_en
//   img_dout       out  8       pixel to consumer
//   img_dout_valid out  1       pixel valid to consumer
//   img_eye        out  1       0 = left, 1 = right (meaningful while valid)
// -----------------------------------------------------------------------------
module stereo_frame_tx #(
  parameter int IMG_HEIGHT = 100,
  parameter int IMG_WIDTH  = 120,
  parameter int GAP_CYCLES = 4,
  parameter int ADDR_W     = $clog2(2 * IMG_HEIGHT * IMG_WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef STEREO_TX_TESTPAT_EN
  input  logic              test_mode,
`endif
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [7:0]        img_dout,
  output logic              img_dout_valid,
  output logic              img_eye
);

  localparam int N     = IMG_HEIGHT * IMG_WIDTH;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  // The gap counter must reach GAP_CYCLES+1 (see S_GAP_R).
  localparam int GAP_W = $clog2(GAP_CYCLES + 2);

  localparam logic [ADDR_W-1:0] ADDR_L_LAST  = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] ADDR_R_FIRST = ADDR_W'(N);
  localparam logic [ADDR_W-1:0] ADDR_R_LAST  = ADDR_W'(2 * N - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST     = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0]  COL_LAST     = COL_W'(IMG_WIDTH - 1);
  localparam logic [GAP_W-1:0]  GAP_L_LAST   = GAP_W'(GAP_CYCLES - 1);
  // The right gap is counted from the last issued address. The two pipeline
  // stages add two cycles before the output itself has been low GAP_CYCLES.
  localparam logic [GAP_W-1:0]  GAP_R_LAST   = GAP_W'(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_L,
    S_GAP_L,
    S_RD_R,
    S_GAP_R
  } state_t;

  state_t            state;
  logic [GAP_W-1:0]  gap_cnt;
  logic              rd_act;    // a pixel slot is issued this cycle (either mode)
  logic              rd_eye;    // eye of the slot being issued
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic              p1_valid;  // stage aligned with mem_data
  logic              p1_eye;
  logic [7:0]        pixel_src;
  logic              mem_on_start;  // read RAM for the pair being accepted
  logic              mem_on_run;    // read RAM for the pair in flight

`ifdef STEREO_TX_TESTPAT_EN
  logic       tm_q;
  logic [7:0] p1_pat;

  assign mem_on_start = ~test_mode;
  assign mem_on_run   = ~tm_q;
  assign pixel_src    = tm_q ? p1_pat : mem_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tm_q   <= 1'b0;
      p1_pat <= 8'd0;
    end else begin
      if (state == S_IDLE && start) tm_q <= test_mode;
      p1_pat <= 8'(row) ^ (8'(col) + (rd_eye ? 8'd4 : 8'd0));
    end
  end
`else
  assign mem_on_start = 1'b1;
  assign mem_on_run   = 1'b1;
  assign pixel_src    = mem_data;
`endif

  // Control FSM. mem_en and mem_addr are registered outputs that follow state.
  // NOTE: every sequential block uses non-blocking assignments. All registers
  // then update together at the edge, and the order of statements cannot
  // create a race.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_en   <= 1'b0;
      mem_addr <= '0;
      rd_act   <= 1'b0;
      rd_eye   <= 1'b0;
      gap_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RD_L;
            busy     <= 1'b1;
            rd_act   <= 1'b1;
            rd_eye   <= 1'b0;
            mem_en   <= mem_on_start;
            mem_addr <= '0;
          end
        end
        S_RD_L: begin
          if (mem_addr == ADDR_L_LAST) begin
            state   <= S_GAP_L;
            rd_act  <= 1'b0;
            mem_en  <= 1'b0;
            gap_cnt <= '0;
          end else begin
            mem_addr <= mem_addr + 1'b1;
          end
        end
        S_GAP_L: begin
          // Issue and output are equally delayed, so an issue gap of
          // GAP_CYCLES gives the same low run on the output.
          if (gap_cnt == GAP_L_LAST) begin
            state    <= S_RD_R;
            rd_act   <= 1'b1;
            rd_eye   <= 1'b1;
            mem_en   <= mem_on_run;
            mem_addr <= ADDR_R_FIRST;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        S_RD_R: begin
          if (mem_addr == ADDR_R_LAST) begin
            state   <= S_GAP_R;
            rd_act  <= 1'b0;
            mem_en  <= 1'b0;
            gap_cnt <= '0;
          end else begin
            mem_addr <= mem_addr + 1'b1;
          end
        end
        S_GAP_R: begin
          if (gap_cnt == GAP_R_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Raster position of the slot currently being issued. Both counters wrap
  // back to zero at the end of each eye.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (state == S_IDLE && start) begin
      row <= '0;
      col <= '0;
    end else if (rd_act) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Two-stage output pipeline. Stage 1 lines up with the RAM read latency,
  // and stage 2 is the registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_valid       <= 1'b0;
      p1_eye         <= 1'b0;
      img_dout_valid <= 1'b0;
      img_dout       <= 8'd0;
      img_eye        <= 1'b0;
    end else begin
      p1_valid       <= rd_act;
      p1_eye         <= rd_eye;
      img_dout_valid <= p1_valid;
      if (p1_valid) begin
        img_dout <= pixel_src;
        img_eye  <= p1_eye;
      end
    end
  end

endmodule

// File: tb/tb_stereo_frame_tx.sv
module tb_stereo_frame_tx;

  localparam int H   = 2;
  localparam int W   = 3;
  localparam int GAP = 4;
  localparam int N   = H * W;
  localparam int AW  = $clog2(2 * N);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data = 8'd0;
  logic [7:0]    img_dout;
  logic          img_dout_valid;
  logic          img_eye;
`ifdef STEREO_TX_TESTPAT_EN
  logic          test_mode = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  stereo_frame_tx #(
    .IMG_HEIGHT(H),
    .IMG_WIDTH (W),
    .GAP_CYCLES(GAP),
    .ADDR_W    (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
`ifdef STEREO_TX_TESTPAT_EN
    .test_mode     (test_mode),
`endif
    .busy          (busy),
    .done          (done),
    .mem_en        (mem_en),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .img_dout      (img_dout),
    .img_dout_valid(img_dout_valid),
    .img_eye       (img_eye)
  );

  always #5 clk = ~clk;

  // Frame RAM with one-cycle read latency, preloaded so that data equals the address.
  always @(posedge clk) if (mem_en) mem_data <= 8'(mem_addr);

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs at cycle T+i after a start pulse in cycle T. A value of -1 means "don't care".
  typedef struct {
    int en; int addr; int valid; int dout; int eye; int busy; int done;
  } vec_t;
  vec_t tbl[25];

  // State used by the stream monitor for the back-to-back test.
  int   prev_valid, run_len, low_run, bursts, pix_idx, pix_total;

  task automatic mon_step();
    @(negedge clk);
    if (img_dout_valid) begin
      if (!prev_valid) begin
        if (bursts > 0) begin
          if (pix_idx >= N) check("gap_in_pair", low_run, GAP);
          else              check("gap_between_pairs_min", int'(low_run >= GAP + 1), 1);
        end
        run_len = 0;
      end
      run_len++;
      check("stream_dout", img_dout, pix_idx);
      check("stream_eye", img_eye, (pix_idx >= N) ? 1 : 0);
      pix_idx = (pix_idx + 1) % (2 * N);
      pix_total++;
    end else begin
      if (prev_valid) begin
        bursts++;
        check("burst_len", run_len, N);
        low_run = 0;
      end
      low_run++;
    end
    prev_valid = img_dout_valid;
  endtask

  initial begin
    int n_en, n_val, n_done;
    tbl[0]  = '{0,  0, 0, -1, -1, 0, 0};
    tbl[1]  = '{1,  0, 0, -1, -1, 1, 0};
    tbl[2]  = '{1,  1, 0, -1, -1, 1, 0};
    tbl[3]  = '{1,  2, 1,  0,  0, 1, 0};
    tbl[4]  = '{1,  3, 1,  1,  0, 1, 0};
    tbl[5]  = '{1,  4, 1,  2,  0, 1, 0};
    tbl[6]  = '{1,  5, 1,  3,  0, 1, 0};
    tbl[7]  = '{0, -1, 1,  4,  0, 1, 0};
    tbl[8]  = '{0, -1, 1,  5,  0, 1, 0};
    tbl[9]  = '{0, -1, 0, -1, -1, 1, 0};
    tbl[10] = '{0, -1, 0, -1, -1, 1, 0};
    tbl[11] = '{1,  6, 0, -1, -1, 1, 0};
    tbl[12] = '{1,  7, 0, -1, -1, 1, 0};
    tbl[13] = '{1,  8, 1,  6,  1, 1, 0};
    tbl[14] = '{1,  9, 1,  7,  1, 1, 0};
    tbl[15] = '{1, 10, 1,  8,  1, 1, 0};
    tbl[16] = '{1, 11, 1,  9,  1, 1, 0};
    tbl[17] = '{0, -1, 1, 10,  1, 1, 0};
    tbl[18] = '{0, -1, 1, 11,  1, 1, 0};
    tbl[19] = '{0, -1, 0, -1, -1, 1, 0};
    tbl[20] = '{0, -1, 0, -1, -1, 1, 0};
    tbl[21] = '{0, -1, 0, -1, -1, 1, 0};
    tbl[22] = '{0, -1, 0, -1, -1, 1, 0};
    tbl[23] = '{0, -1, 0, -1, -1, 0, 1};
    tbl[24] = '{0, -1, 0, -1, -1, 0, 0};

    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_valid", img_dout_valid, 0);
    check("rst_dout", img_dout, 0);
    check("rst_eye", img_eye, 0);

    // Single pair: timing table
    @(negedge clk);
    for (int i = 0; i < 25; i++) begin
      if (i == 0) start = 1'b1;
      else begin
        @(negedge clk);
        start = 1'b0;
      end
      check($sformatf("t%0d_mem_en", i), mem_en, tbl[i].en);
      if (tbl[i].addr >= 0) check($sformatf("t%0d_addr", i), mem_addr, tbl[i].addr);
      check($sformatf("t%0d_valid", i), img_dout_valid, tbl[i].valid);
      if (tbl[i].dout >= 0) check($sformatf("t%0d_dout", i), img_dout, tbl[i].dout);
      if (tbl[i].eye >= 0)  check($sformatf("t%0d_eye", i), img_eye, tbl[i].eye);
      check($sformatf("t%0d_busy", i), busy, tbl[i].busy);
      check($sformatf("t%0d_done", i), done, tbl[i].done);
    end

    // start pulses during RD_L and GAP_R must be ignored
    repeat (3) @(negedge clk);
    start = 1'b1;
    n_en = 0; n_val = 0; n_done = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = (k == 4 || k == 20) ? 1'b1 : 1'b0;
      n_en   += int'(mem_en);
      n_val  += int'(img_dout_valid);
      n_done += int'(done);
    end
    check("ignore_start_mem_en_count", n_en, 2 * N);
    check("ignore_start_valid_count", n_val, 2 * N);
    check("ignore_start_done_count", n_done, 1);
    check("ignore_start_idle", busy, 0);

    // start held high for 60 cycles: back-to-back pairs
    prev_valid = 0; run_len = 0; low_run = 0; bursts = 0; pix_idx = 0; pix_total = 0;
    start = 1'b1;
    for (int k = 1; k <= 160; k++) begin
      mon_step();
      if (k == 60) start = 1'b0;
    end
    check("b2b_bursts", bursts, 6);
    check("b2b_pixels", pix_total, 6 * N);
    check("b2b_idle", busy, 0);

    // Asynchronous reset in the middle of RD_R
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    check("pre_rst_mem_en", mem_en, 1);
    check("pre_rst_valid", img_dout_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_mem_en", mem_en, 0);
    check("async_rst_valid", img_dout_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_addr", mem_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_mem_en", mem_en, 1);
    check("restart_addr", mem_addr, 0);
    check("restart_busy", busy, 1);
    repeat (30) @(negedge clk);
    check("restart_idle", busy, 0);

`ifdef STEREO_TX_TESTPAT_EN
    // Test-pattern mode
    begin
      logic [7:0] exp_pat [12];
      int n_pix;
      exp_pat = '{8'd0, 8'd1, 8'd2, 8'd1, 8'd0, 8'd3, 8'd4, 8'd5, 8'd6, 8'd5, 8'd4, 8'd7};
      n_pix = 0; n_en = 0;
      test_mode = 1'b1;
      start = 1'b1;
      for (int k = 1; k <= 30; k++) begin
        @(negedge clk);
        start = 1'b0;
        test_mode = 1'b0;
        n_en += int'(mem_en);
        if (img_dout_valid) begin
          if (n_pix < 12) begin
            check($sformatf("tp_pix%0d", n_pix), img_dout, exp_pat[n_pix]);
            check($sformatf("tp_eye%0d", n_pix), img_eye, (n_pix >= N) ? 1 : 0);
          end
          n_pix++;
        end
      end
      check("tp_pixel_count", n_pix, 2 * N);
      check("tp_mem_en_never", n_en, 0);
      check("tp_idle", busy, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
